// File: rtl/chord_voice_mixer.sv
// Ten-voice square-wave synthesizer: sums the voices enabled by the note mask and
// emits signed 16-bit PCM samples at a fixed rate over a valid/ready handshake.
module chord_voice_mixer #(
  parameter int unsigned SAMPLE_DIV = 1042,
  parameter int signed   VOICE_AMP  = 3000,
  parameter int unsigned CNT_W      = 17
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  note_mask,
  input  logic        sample_ready,
  output logic        sample_valid,
  output logic [15:0] sample_data,
  output logic [7:0]  overrun_count
);

  localparam int unsigned NV     = 10;
  localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
  localparam int unsigned ACC_W  = 20;
  localparam int unsigned OUT_W  = 16;
  localparam int unsigned OVR_W  = 8;

  // Half-periods in clk cycles, C4 (bit 0) through E5 (bit 9)
  localparam logic [CNT_W-1:0] HALF [NV] = '{
    CNT_W'(95556), CNT_W'(85131), CNT_W'(75843), CNT_W'(71586), CNT_W'(63776),
    CNT_W'(56818), CNT_W'(50619), CNT_W'(47778), CNT_W'(42566), CNT_W'(37921)
  };

  localparam logic signed [ACC_W-1:0] AMP    = ACC_W'(VOICE_AMP);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t                 state_q, state_d;
  logic [NV-1:0]          sync1_q, sync1_d;
  logic [NV-1:0]          mask_s_q, mask_s_d;
  logic [CNT_W-1:0]       cnt_q [NV];
  logic [CNT_W-1:0]       cnt_d [NV];
  logic [NV-1:0]          phase_q, phase_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic                   sample_valid_q, sample_valid_d;
  logic [OUT_W-1:0]       sample_data_q, sample_data_d;
  logic [OVR_W-1:0]       overrun_q, overrun_d;

  logic                   tick_c;
  logic signed [ACC_W-1:0] acc_c;
  logic [OUT_W-1:0]       mix_c;

  // Synchronizer and per-voice oscillators; a disabled voice restarts from phase 0
  always_comb begin
    sync1_d  = note_mask;
    mask_s_d = sync1_q;
    phase_d  = phase_q;
    for (int i = 0; i < NV; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!mask_s_q[i]) begin
        cnt_d[i]   = '0;
        phase_d[i] = 1'b0;
      end else if (cnt_q[i] == HALF[i] - CNT_W'(1)) begin
        cnt_d[i]   = '0;
        phase_d[i] = ~phase_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Sample-rate tick
  always_comb begin
    tick_c     = (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Voice sum with saturation to the 16-bit PCM range
  always_comb begin
    acc_c = '0;
    for (int i = 0; i < NV; i++) begin
      if (mask_s_q[i]) begin
        acc_c = phase_q[i] ? (acc_c + AMP) : (acc_c - AMP);
      end
    end
    if (acc_c > SAT_HI) begin
      mix_c = 16'h7FFF;
    end else if (acc_c < SAT_LO) begin
      mix_c = 16'h8000;
    end else begin
      mix_c = acc_c[OUT_W-1:0];
    end
  end

  // Output handshake: newest sample wins, dropped samples are counted
  always_comb begin
    state_d        = state_q;
    sample_valid_d = sample_valid_q;
    sample_data_d  = sample_data_q;
    overrun_d      = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (tick_c) begin
          sample_data_d  = mix_c;
          sample_valid_d = 1'b1;
          state_d        = PENDING;
        end
      end
      PENDING: begin
        if (tick_c) begin
          sample_data_d = mix_c;
          if (!sample_ready && (overrun_q != '1)) begin
            overrun_d = overrun_q + OVR_W'(1);
          end
        end else if (sample_ready) begin
          sample_valid_d = 1'b0;
          state_d        = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      sync1_q        <= '0;
      mask_s_q       <= '0;
      phase_q        <= '0;
      tick_cnt_q     <= '0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= '0;
      overrun_q      <= '0;
      for (int i = 0; i < NV; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      mask_s_q       <= mask_s_d;
      phase_q        <= phase_d;
      tick_cnt_q     <= tick_cnt_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      overrun_q      <= overrun_d;
      for (int i = 0; i < NV; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sample_valid  = sample_valid_q;
  assign sample_data   = sample_data_q;
  assign overrun_count = overrun_q;

endmodule

// File: tb/tb_chord_voice_mixer.sv
// Directed bench for chord_voice_mixer: sample timing, voice mixing,
// saturation, overrun counting and asynchronous reset.
module tb_chord_voice_mixer;

  logic        clk;
  logic        resetn;
  logic [9:0]  note_mask;
  logic        sample_ready;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic [7:0]  overrun_count;
  logic        sat_valid;
  logic [15:0] sat_data;
  logic [7:0]  sat_overrun;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  localparam int DIV = 1042;

  chord_voice_mixer dut (
    .clk(clk), .resetn(resetn), .note_mask(note_mask), .sample_ready(sample_ready),
    .sample_valid(sample_valid), .sample_data(sample_data), .overrun_count(overrun_count)
  );

  chord_voice_mixer #(.VOICE_AMP(4000)) dut_sat (
    .clk(clk), .resetn(resetn), .note_mask(note_mask), .sample_ready(sample_ready),
    .sample_valid(sat_valid), .sample_data(sat_data), .overrun_count(sat_overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Rising edges since the last reset release
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic apply_reset(input logic [9:0] mask, input logic ready);
    note_mask    = mask;
    sample_ready = ready;
    resetn       = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_valid(input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sample_valid) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_valid: sample_valid=0 after %0d cycles, required 1", budget);
    end
  endtask

  task automatic test_reset();
    note_mask = '0; sample_ready = 1'b1; resetn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (sample_valid !== 1'b0 || sample_data !== 16'h0 || overrun_count !== 8'h0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h ovr=%0d, required 0/0000/0",
               sample_valid, sample_data, overrun_count);
    end
    resetn = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      wait_valid(DIV + 20);
      tests++;
      if (cyc !== DIV * j) begin
        fails++;
        $display("FAIL silence_timing[%0d]: valid at cycle %0d, required %0d", j, cyc, DIV * j);
      end
      tests++;
      if (sample_data !== 16'h0) begin
        fails++;
        $display("FAIL silence_data[%0d]: got %0d, required 0", j, $signed(sample_data));
      end
      @(negedge clk);
      tests++;
      if (sample_valid !== 1'b0) begin
        fails++;
        $display("FAIL silence_pulse[%0d]: valid=%b one cycle later, required 0", j, sample_valid);
      end
    end
    tests++;
    if (overrun_count !== 8'h0) begin
      fails++;
      $display("FAIL silence_overrun: got %0d, required 0", overrun_count);
    end
  endtask

  task automatic test_full_chord();
    logic signed [15:0] exp_mix;
    exp_mix = -16'sd30000;
    apply_reset(10'h3FF, 1'b1);
    for (int j = 1; j <= 2; j++) begin
      wait_valid(DIV + 20);
      tests++;
      if (sample_data !== exp_mix) begin
        fails++;
        $display("FAIL full_chord[%0d]: got %0d, required %0d", j, $signed(sample_data), exp_mix);
      end
      tests++;
      if (sat_valid !== 1'b1 || sat_data !== 16'h8000) begin
        fails++;
        $display("FAIL full_chord_sat[%0d]: valid=%b data=%0d, required 1/-32768",
                 j, sat_valid, $signed(sat_data));
      end
    end
  endtask

  task automatic test_overrun();
    apply_reset('0, 1'b0);
    wait_valid(DIV + 20);
    while (cyc < 2 * DIV + 6) @(negedge clk);
    tests++;
    if (sample_valid !== 1'b1 || overrun_count !== 8'd1 || sample_data !== 16'h0) begin
      fails++;
      $display("FAIL overrun_two_ticks: valid=%b ovr=%0d data=%0d, required 1/1/0",
               sample_valid, overrun_count, $signed(sample_data));
    end
    sample_ready = 1'b1;
    @(negedge clk);
    sample_ready = 1'b0;
    tests++;
    if (sample_valid !== 1'b0 || overrun_count !== 8'd1) begin
      fails++;
      $display("FAIL overrun_drain: valid=%b ovr=%0d, required 0/1", sample_valid, overrun_count);
    end
    // Ready asserted exactly in a tick cycle: old sample consumed, new one loaded, no drop
    wait_valid(DIV + 20);
    while (cyc < 4 * DIV - 1) @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (sample_valid !== 1'b1 || overrun_count !== 8'd1) begin
      fails++;
      $display("FAIL tick_with_ready: valid=%b ovr=%0d, required 1/1", sample_valid, overrun_count);
    end
    @(negedge clk);
    tests++;
    if (sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL tick_with_ready_drain: valid=%b, required 0", sample_valid);
    end
  endtask

  task automatic test_a4_toggle();
    logic signed [15:0] exp_a4;
    apply_reset(10'b0000100000, 1'b1);
    // A4 phase flips at edge 56820; sample j is mixed just before edge 1042*j
    for (int j = 1; j <= 55; j++) begin
      wait_valid(DIV + 20);
      exp_a4 = (j <= 54) ? -16'sd3000 : 16'sd3000;
      tests++;
      if (sample_data !== exp_a4) begin
        fails++;
        $display("FAIL a4_sample[%0d]: got %0d, required %0d", j, $signed(sample_data), exp_a4);
      end
    end
    tests++;
    if (cyc !== 55 * DIV) begin
      fails++;
      $display("FAIL a4_timing: sample 55 at cycle %0d, required %0d", cyc, 55 * DIV);
    end
    note_mask = '0;
    wait_valid(DIV + 20);
    tests++;
    if (sample_data !== 16'h0) begin
      fails++;
      $display("FAIL a4_cleared: got %0d, required 0", $signed(sample_data));
    end
    note_mask = 10'b0000100000;
    wait_valid(DIV + 20);
    tests++;
    if (sample_data !== 16'hF448) begin
      fails++;
      $display("FAIL a4_reenable: got %0d, required -3000", $signed(sample_data));
    end
  endtask

  task automatic test_async_reset();
    apply_reset(10'b0000100000, 1'b0);
    wait_valid(DIV + 20);
    while (cyc < 2 * DIV + 6) @(negedge clk);
    tests++;
    if (sample_valid !== 1'b1 || sample_data !== 16'hF448 || overrun_count !== 8'd1) begin
      fails++;
      $display("FAIL pre_pulse: valid=%b data=%0d ovr=%0d, required 1/-3000/1",
               sample_valid, $signed(sample_data), overrun_count);
    end
    @(posedge clk);
    #2 resetn = 1'b0;
    #3 resetn = 1'b1;
    #1;
    tests++;
    if (sample_valid !== 1'b0 || sample_data !== 16'h0 || overrun_count !== 8'h0) begin
      fails++;
      $display("FAIL async_reset: valid=%b data=%h ovr=%0d, required 0/0000/0",
               sample_valid, sample_data, overrun_count);
    end
    wait_valid(DIV + 20);
    tests++;
    if (cyc !== DIV || sample_data !== 16'hF448) begin
      fails++;
      $display("FAIL post_pulse: valid at cycle %0d data=%0d, required %0d/-3000",
               cyc, $signed(sample_data), DIV);
    end
  endtask

  initial begin
    resetn = 1'b0; note_mask = '0; sample_ready = 1'b0;
    test_reset();
    test_full_chord();
    test_overrun();
    test_a4_toggle();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chord_voice_mixer.md
Name: chord_voice_mixer

Overview:
- Downstream stage of the chord machine. Consumes the 10-bit active-note mask that the chord registers produce, one bit per note.
- Runs one square-wave oscillator per note and sums the active voices at a fixed sample rate.
- Presents signed 16-bit PCM samples to the audio output path over a valid/ready handshake.
- Replaces the LED display as the consumer of the note mask.

Parameters:
- SAMPLE_DIV, 1042: clk cycles per output sample (50 MHz / 1042 ≈ 48 kHz).
- VOICE_AMP, 3000: per-voice amplitude magnitude (signed, positive).
- CNT_W, 17: width of the per-voice half-period counters.

Ports:
- clk  in  1  50 MHz system clock (CLOCK_50 at top level).
- resetn  in  1  asynchronous, active-low reset.
- note_mask  in  10  active notes. Bit0=C4, 1=D4, 2=E4, 3=F4, 4=G4, 5=A4, 6=B4, 7=C5, 8=D5, 9=E5. Asynchronous to clk (key-derived).
- sample_ready  in  1  downstream can accept a sample this cycle.
- sample_valid  out  1  sample_data holds an unconsumed sample.
- sample_data  out  16  signed two's-complement PCM sample.
- overrun_count  out  8  samples dropped because downstream was not ready; saturates at 255.

Behaviour:
- Reset (resetn=0, asynchronous, no clock needed):
  - sample_valid=0, sample_data=0, overrun_count=0.
  - All voice counters=0, all phases=0, tick counter=0, synchronizer flops=0.
- Input sync: note_mask passes through a 2-flop synchronizer (mask_s). Any mask change affects voices 2 cycles later.
- Half-periods are fixed constants in clk cycles:
  - C4 95556, D4 85131, E4 75843, F4 71586, G4 63776
  - A4 56818, B4 50619, C5 47778, D5 42566, E5 37921
- Voice n, when mask_s[n]=0: counter held at 0, phase held at 0. Re-enabling always restarts from phase 0.
- Voice n, when mask_s[n]=1:
  - Counter increments each cycle.
  - At HALF[n]-1 the counter wraps to 0 and phase toggles on the same edge.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick=1 in the cycle where the count equals SAMPLE_DIV-1. The first tick occurs at cycle SAMPLE_DIV-1 after reset release.
- Mix, evaluated in the tick cycle using the current phases and mask_s:
  - Each active voice contributes +VOICE_AMP when phase=1 and -VOICE_AMP when phase=0. Inactive voices contribute 0.
  - Accumulate in 20-bit signed, then saturate to [-32768, 32767].
  - The result is loaded into sample_data on the edge ending the tick cycle.
- Output FSM, states IDLE and PENDING:
  - IDLE, tick: load sample, sample_valid=1 from the next cycle; go to PENDING.
  - PENDING, sample_ready=1 and no tick: handshake completes this cycle; sample_valid=0 next cycle; go to IDLE.
  - PENDING, tick and sample_ready=1: the old sample is consumed and the new sample is loaded; stay PENDING; no overrun.
  - PENDING, tick and sample_ready=0: the new sample overwrites the old (newest wins); overrun_count++ (saturating); stay PENDING.
  - sample_data is stable while sample_valid=1 and no tick occurs.
- An all-zero mask (write mode upstream) still produces samples of value 0. Silence is a stream of zeros, not an absence of valid.
- Latency: one clk cycle from tick to sample_valid. Mask change to sample effect: 2 sync cycles plus wait to the next tick.
- resetn asserted mid-sample or mid-handshake: immediate return to reset values. No partial sample is emitted after release.

Test Plan:
- Reset release, mask=0, sample_ready=1 -> sample_valid pulses for 1 cycle every 1042 cycles with sample_data=0; overrun_count=0.
- mask=10'b0000100000 (A4), ready=1:
  - samples are -3000 until the A4 phase toggles at 2+56818 cycles after mask applied;
  - subsequent samples are +3000;
  - sign alternates every 56818 cycles.
- mask=10'h3FF held from reset -> first sample -30000. With VOICE_AMP=4000 the first sample saturates to -32768.
- ready=0 across two ticks with mask=0 -> sample_valid stays 1, overrun_count=1. Raise ready for one cycle -> sample_valid=0 the following cycle.
- A4 active past its first toggle (phase=1), then clear mask bit5 -> 2 cycles later counter=0 and phase=0; the next sample is 0; re-enable gives -3000.
- Pulse resetn low for 3 ns between clock edges while PENDING -> sample_valid, sample_data and overrun_count read 0 before the next rising edge.
